// File: rtl/bram_port_scheduler_pkg.sv
// Shared types for the frame block RAM port scheduler: widths, FSM states,
// stream identifiers, read-return tags and the frame-size clamp helper.
// Purpose: common definitions; latency: n/a; backpressure: n/a.
package bram_port_scheduler_pkg;

  localparam int ADDR_W_DEF     = 14;
  localparam int DATA_W_DEF     = 16;
  localparam int STEAL_WAIT_DEF = 8;

  // Largest frame is 2^13 words: half of the 16K RAM.
  localparam logic [3:0] MAX_FRAME_LOG2 = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FFT_BURST  = 2'd1,
    ST_IFFT_BURST = 2'd2
  } state_t;

  typedef enum logic {
    STREAM_FFT  = 1'b0,
    STREAM_IFFT = 1'b1
  } stream_t;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CORE = 2'd1,
    TAG_IFFT = 2'd2
  } rd_tag_t;

  function automatic logic [3:0] clamp_frame_size(input logic [3:0] size);
    return (size > MAX_FRAME_LOG2) ? MAX_FRAME_LOG2 : size;
  endfunction

endpackage

// File: rtl/bram_port_scheduler_if.sv
// Bundle between the scheduler and its neighbours (FFT writer, IFFT reader,
// processing core, RAM port A). slave = scheduler side, master = environment.
// Purpose: port grouping; latency: n/a; backpressure: n/a.
interface bram_port_scheduler_if
  import bram_port_scheduler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [3:0]        frame_size;
  logic [ADDR_W-1:0] fft_base;
  logic [ADDR_W-1:0] ifft_base;
  logic              fft_frame_ready;
  logic [DATA_W-1:0] fft_din;
  logic              fft_pop;
  logic              fft_done;
  logic              ifft_frame_ready;
  logic [DATA_W-1:0] ifft_dout;
  logic              ifft_valid;
  logic              ifft_done;
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid;
  logic [ADDR_W-1:0] blk_addr;
  logic              blk_we;
  logic [DATA_W-1:0] blk_din;
  logic [DATA_W-1:0] blk_dout;
  logic              busy;

  modport slave (
    input  frame_size, fft_base, ifft_base, fft_frame_ready, fft_din,
           ifft_frame_ready, core_req, core_we, core_addr, core_wdata, blk_dout,
    output fft_pop, fft_done, ifft_dout, ifft_valid, ifft_done, core_gnt,
           core_rdata, core_rvalid, blk_addr, blk_we, blk_din, busy
  );

  modport master (
    output frame_size, fft_base, ifft_base, fft_frame_ready, fft_din,
           ifft_frame_ready, core_req, core_we, core_addr, core_wdata, blk_dout,
    input  fft_pop, fft_done, ifft_dout, ifft_valid, ifft_done, core_gnt,
           core_rdata, core_rvalid, blk_addr, blk_we, blk_din, busy
  );
endinterface

// File: rtl/bram_port_scheduler_burst_addr_gen.sv
// Burst address generator: latches base and clamped frame size on start,
// counts words while advance is high (holds otherwise), flags word N-1.
// Ports: start/base/size load, advance steps, addr = base+cnt mod 2^ADDR_W, last.
module bram_port_scheduler_burst_addr_gen
  import bram_port_scheduler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [3:0]        size,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] last_idx;
  logic [3:0]        size_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      cnt_q  <= '0;
      size_q <= '0;
    end else if (start) begin
      base_q <= base;
      cnt_q  <= '0;
      size_q <= clamp_frame_size(size);
    end else if (advance) begin
      cnt_q <= cnt_q + ADDR_W'(1);
    end
  end

  assign last_idx = (ADDR_W'(1) << size_q) - ADDR_W'(1);
  // Plain ADDR_W-bit add: frames crossing the top of the RAM wrap to 0.
  assign addr     = base_q + cnt_q;
  assign last     = (cnt_q == last_idx);
endmodule

// File: rtl/bram_port_scheduler.sv
// Schedules RAM port A among FFT frame writes, IFFT frame reads and core single-word slots.
// Latency: RAM port registered 1 cycle after grant/issue; read data returns 2 cycles after.
// Backpressure: streams start only on frame-ready levels; core holds core_req until core_gnt.
// Ports: clk, rst (sync, active high), bus (slave modport of bram_port_scheduler_if).
// Option: CORE_STEAL_EN lets a core request waiting STEAL_WAIT cycles steal one burst slot.
module bram_port_scheduler
  import bram_port_scheduler_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STEAL_WAIT = STEAL_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  bram_port_scheduler_if.slave  bus
);
  state_t            state_q, state_d;
  stream_t           last_stream_q, start_stream;
  logic              prev_burst_q;
  logic              start, core_slot, advance, steal_now, fft_pop;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;
  logic [ADDR_W-1:0] blk_addr_q;
  logic              blk_we_q;
  logic [DATA_W-1:0] blk_din_q;
  rd_tag_t           tag1_q, tag2_q;
  logic              last1_q, last2_q;
  logic              fft_done_q;

  bram_port_scheduler_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .base    ((start_stream == STREAM_FFT) ? bus.fft_base : bus.ifft_base),
    .size    (bus.frame_size),
    .advance (advance),
    .addr    (gen_addr),
    .last    (gen_last)
  );

`ifdef CORE_STEAL_EN
  localparam int WAIT_W = $clog2(STEAL_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(STEAL_WAIT);
  logic [WAIT_W-1:0] wait_cnt_q;

  assign steal_now = bus.core_req && (state_q != ST_IDLE) && (wait_cnt_q == WAIT_LIM);

  always_ff @(posedge clk) begin
    if (rst || state_q == ST_IDLE || core_slot) begin
      wait_cnt_q <= '0;
    end else if (bus.core_req && wait_cnt_q != WAIT_LIM) begin
      wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
    end
  end
`else
  assign steal_now = 1'b0;
`endif

  // One decision per cycle. Nothing is granted while rst is high.
  always_comb begin
    state_d      = state_q;
    start        = 1'b0;
    start_stream = STREAM_FFT;
    core_slot    = 1'b0;
    advance      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          // A core waiting behind a burst goes before the next burst.
          if (bus.core_req && prev_burst_q) begin
            core_slot = 1'b1;
          end else if (bus.fft_frame_ready && bus.ifft_frame_ready) begin
            start        = 1'b1;
            start_stream = (last_stream_q == STREAM_IFFT) ? STREAM_FFT : STREAM_IFFT;
          end else if (bus.fft_frame_ready) begin
            start        = 1'b1;
            start_stream = STREAM_FFT;
          end else if (bus.ifft_frame_ready) begin
            start        = 1'b1;
            start_stream = STREAM_IFFT;
          end else if (bus.core_req) begin
            core_slot = 1'b1;
          end
          if (start) begin
            state_d = (start_stream == STREAM_FFT) ? ST_FFT_BURST : ST_IFFT_BURST;
          end
        end
        ST_FFT_BURST, ST_IFFT_BURST: begin
          // A stolen slot freezes the burst counter for one cycle.
          if (steal_now) begin
            core_slot = 1'b1;
          end else begin
            advance = 1'b1;
            if (gen_last) state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign fft_pop = (state_q == ST_FFT_BURST) && advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_stream_q <= STREAM_IFFT;
      prev_burst_q  <= 1'b0;
      blk_addr_q    <= '0;
      blk_we_q      <= 1'b0;
      blk_din_q     <= '0;
      tag1_q        <= TAG_NONE;
      tag2_q        <= TAG_NONE;
      last1_q       <= 1'b0;
      last2_q       <= 1'b0;
      fft_done_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fft_done_q <= fft_pop && gen_last;
      tag2_q     <= tag1_q;
      last2_q    <= last1_q;
      blk_we_q   <= 1'b0;
      tag1_q     <= TAG_NONE;
      last1_q    <= 1'b0;
      if (start) begin
        last_stream_q <= start_stream;
        prev_burst_q  <= 1'b1;
      end
      if (core_slot) begin
        prev_burst_q <= 1'b0;
        blk_addr_q   <= bus.core_addr;
        blk_we_q     <= bus.core_we;
        tag1_q       <= bus.core_we ? TAG_NONE : TAG_CORE;
        if (bus.core_we) blk_din_q <= bus.core_wdata;
      end else if (advance) begin
        blk_addr_q <= gen_addr;
        if (state_q == ST_FFT_BURST) begin
          blk_we_q  <= 1'b1;
          blk_din_q <= bus.fft_din;
        end else begin
          tag1_q  <= TAG_IFFT;
          last1_q <= gen_last;
        end
      end
    end
  end

  // Read data passes straight from the RAM, qualified by the return tag.
  assign bus.fft_pop     = fft_pop;
  assign bus.fft_done    = fft_done_q;
  assign bus.ifft_valid  = (tag2_q == TAG_IFFT);
  assign bus.ifft_done   = (tag2_q == TAG_IFFT) && last2_q;
  assign bus.ifft_dout   = (tag2_q == TAG_IFFT) ? bus.blk_dout : '0;
  assign bus.core_gnt    = core_slot;
  assign bus.core_rvalid = (tag2_q == TAG_CORE);
  assign bus.core_rdata  = (tag2_q == TAG_CORE) ? bus.blk_dout : '0;
  assign bus.blk_addr    = blk_addr_q;
  assign bus.blk_we      = blk_we_q;
  assign bus.blk_din     = blk_din_q;
  assign bus.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_bram_port_scheduler.sv
// Directed bench for bram_port_scheduler with a 1-cycle-latency RAM model.
// Covers reset, core slots, FFT/IFFT bursts, wrap, alternation, core steal and mid-burst reset.
// Expected values are hand-derived cycle numbers and data patterns.
module tb_bram_port_scheduler;
  import bram_port_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_port_scheduler_if bus ();
  bram_port_scheduler dut (.clk(clk), .rst(rst), .bus(bus));

  // RAM model, port A: write on blk_we, read data one cycle after address.
  logic [15:0] mem [0:16383];
  logic [15:0] dout_q;
  always @(posedge clk) begin
    if (bus.blk_we) mem[bus.blk_addr] <= bus.blk_din;
    dout_q <= mem[bus.blk_addr];
  end
  assign bus.blk_dout = dout_q;

  // FFT source: word value = seed + number of words popped so far.
  int          fft_sent = 0;
  int          ifft_valid_cnt = 0;
  int          ifft_done_cnt = 0;
  logic [15:0] fft_seed = 16'h0000;
  assign bus.fft_din = fft_seed + fft_sent[15:0];
  always @(posedge clk) begin
    if (bus.fft_pop)   fft_sent       <= fft_sent + 1;
    if (bus.ifft_valid) ifft_valid_cnt <= ifft_valid_cnt + 1;
    if (bus.ifft_done)  ifft_done_cnt  <= ifft_done_cnt + 1;
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] burst_words [0:255];
  int          s0, pops, gnt_i, done_i, bad, v0, d0;
  logic        pop_at_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.frame_size       = 4'd0;
    bus.fft_base         = 14'h0;
    bus.ifft_base        = 14'h0;
    bus.fft_frame_ready  = 1'b0;
    bus.ifft_frame_ready = 1'b0;
    bus.core_req         = 1'b0;
    bus.core_we          = 1'b0;
    bus.core_addr        = 14'h0;
    bus.core_wdata       = 16'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // FFT burst of n words; mid-burst size/base changes must be ignored.
  task automatic fft_burst(input logic [13:0] base, input logic [3:0] size, input int n,
                           input logic [15:0] seed);
    int          np = 0;
    int          st;
    int          nbad = 0;
    logic [13:0] a;
    @(negedge clk);
    fft_seed = seed;
    bus.fft_base = base;
    bus.frame_size = size;
    bus.fft_frame_ready = 1'b1;
    #1;
    chk("fft_idle_before", bus.busy, 0);
    st = fft_sent;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == 1) begin
        bus.fft_frame_ready = 1'b0;
        bus.frame_size = 4'hF;
        bus.fft_base = 14'h0;
      end
      #1;
      if (bus.fft_pop) np++;
      if (i == 2) begin
        chk("fft_first_addr", bus.blk_addr, base);
        chk("fft_first_we", bus.blk_we, 1);
      end
    end
    @(negedge clk); #1;
    chk("fft_pop_count", np, n);
    chk("fft_done_pulse", bus.fft_done, 1);
    chk("fft_pop_after", bus.fft_pop, 0);
    @(negedge clk); #1;
    chk("fft_done_width", bus.fft_done, 0);
    for (int k = 0; k < n; k++) begin
      a = base + 14'(k);
      burst_words[k] = seed + 16'(st + k);
      if (mem[a] !== burst_words[k]) nbad++;
    end
    chk("fft_mem_contents", nbad, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_busy", bus.busy, 0);
    chk("rst_blk_we", bus.blk_we, 0);
    chk("rst_blk_addr", bus.blk_addr, 0);
    chk("rst_fft_pop", bus.fft_pop, 0);
    chk("rst_ifft_valid", bus.ifft_valid, 0);
    chk("rst_core_rvalid", bus.core_rvalid, 0);

    // Core write 0xBEEF to 0x0042, then read it back from IDLE
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 14'h0042; bus.core_wdata = 16'hBEEF;
    #1;
    chk("core_wr_gnt", bus.core_gnt, 1);
    @(negedge clk);
    bus.core_req = 1'b0;
    #1;
    chk("core_wr_we", bus.blk_we, 1);
    chk("core_wr_addr", bus.blk_addr, 14'h0042);
    chk("core_wr_din", bus.blk_din, 16'hBEEF);
    @(negedge clk);
    bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 14'h0042;
    #1;
    chk("core_rd_gnt", bus.core_gnt, 1);
    @(negedge clk);
    bus.core_req = 1'b0;
    #1;
    chk("core_rd_ram_addr", bus.blk_addr, 14'h0042);
    chk("core_rd_rvalid_t1", bus.core_rvalid, 0);
    @(negedge clk); #1;
    chk("core_rd_rvalid_t2", bus.core_rvalid, 1);
    chk("core_rd_data", bus.core_rdata, 16'hBEEF);

    // 16-word FFT burst at 0x0100
    fft_burst(14'h0100, 4'd4, 16, 16'hA000);

    // Preload across the top of RAM, then IFFT read with wrap
    fft_burst(14'h3FFC, 4'd3, 8, 16'hC000);
    @(negedge clk);
    bus.ifft_base = 14'h3FFC; bus.frame_size = 4'd3; bus.ifft_frame_ready = 1'b1;
    #1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      if (i == 1) bus.ifft_frame_ready = 1'b0;
      #1;
      if (i >= 2 && i <= 9) chk("ifft_addr", bus.blk_addr, 14'(14'h3FFC + (i - 2)));
      chk("ifft_valid", bus.ifft_valid, (i >= 3 && i <= 10));
      if (i >= 3 && i <= 10) chk("ifft_data", bus.ifft_dout, burst_words[i - 3]);
      chk("ifft_done", bus.ifft_done, (i == 10));
    end

    // 256-word FFT burst with a core write arriving at count 10
    @(negedge clk);
    fft_seed = 16'h5000; bus.fft_base = 14'h1000; bus.frame_size = 4'd8; bus.fft_frame_ready = 1'b1;
    #1;
    s0 = fft_sent; pops = 0; gnt_i = 0; done_i = 0; pop_at_gnt = 1'b1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (i == 1) bus.fft_frame_ready = 1'b0;
      if (i == 11) begin
        bus.core_req = 1'b1; bus.core_we = 1'b1; bus.core_addr = 14'h0050; bus.core_wdata = 16'h1234;
      end
      if (gnt_i != 0) bus.core_req = 1'b0;
      #1;
      if (bus.fft_pop) pops++;
      if (bus.core_gnt && gnt_i == 0) begin gnt_i = i; pop_at_gnt = bus.fft_pop; end
      if (bus.fft_done && done_i == 0) done_i = i;
      if (gnt_i != 0 && done_i != 0) break;
    end
    @(negedge clk);
    bus.core_req = 1'b0;
`ifdef CORE_STEAL_EN
    chk("steal_gnt_cycle", gnt_i, 19);
    chk("steal_done_cycle", done_i, 258);
    chk("steal_pop_hold", pop_at_gnt, 0);
`else
    chk("nosteal_gnt_cycle", gnt_i, 257);
    chk("nosteal_done_cycle", done_i, 257);
`endif
    chk("long_pop_count", pops, 256);
    repeat (3) @(negedge clk);
    #1;
    chk("long_core_write", mem[14'h0050], 16'h1234);
    bad = 0;
    for (int k = 0; k < 256; k++)
      if (mem[14'h1000 + 14'(k)] !== 16'(16'h5000 + s0 + k)) bad++;
    chk("long_mem_contents", bad, 0);

    // Both streams ready from reset: FFT first, then alternate
    do_reset();
    @(negedge clk);
    bus.frame_size = 4'd2; bus.fft_base = 14'h0200; bus.ifft_base = 14'h0200;
    bus.fft_frame_ready = 1'b1; bus.ifft_frame_ready = 1'b1;
    #1;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk); #1;
      if (i == 1) chk("alt_first_fft", bus.fft_pop, 1);
      if (i == 5) chk("alt_gap_idle", bus.busy, 0);
      if (i == 6) begin
        chk("alt_second_busy", bus.busy, 1);
        chk("alt_second_not_fft", bus.fft_pop, 0);
      end
      if (i == 11) begin
        chk("alt_third_fft", bus.fft_pop, 1);
        chk("alt_ifft_done", bus.ifft_done, 1);
      end
    end
    @(negedge clk);
    bus.fft_frame_ready = 1'b0; bus.ifft_frame_ready = 1'b0;
    #1;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      @(negedge clk); #1;
    end
    chk("alt_back_idle", bus.busy, 0);

    // Reset at word 5 of an IFFT burst
    @(negedge clk);
    bus.ifft_base = 14'h0100; bus.frame_size = 4'd4; bus.ifft_frame_ready = 1'b1;
    #1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) bus.ifft_frame_ready = 1'b0;
      if (i == 6) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_ifft_valid", bus.ifft_valid, 0);
    chk("mrst_ifft_done", bus.ifft_done, 0);
    chk("mrst_blk_addr", bus.blk_addr, 0);
    chk("mrst_blk_we", bus.blk_we, 0);
    v0 = ifft_valid_cnt;
    d0 = ifft_done_cnt;
    repeat (10) @(negedge clk);
    #1;
    chk("mrst_no_stray_valid", ifft_valid_cnt - v0, 0);
    chk("mrst_no_done", ifft_done_cnt - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
